// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus controller: FSM states, address field
// positions, and the data value returned on a failed access.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_SLOTS_C        = 4;
  localparam int DATA_W             = 16;
  localparam int ADDR_W             = 16;
  localparam int OFFSET_W           = 12;
  localparam int SLOT_LSB           = 12;
  localparam int SLOT_W             = 2;
  localparam int UNMAPPED_BIT       = 14;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  localparam logic [DATA_W-1:0] IO_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/io_bus_controller_if.sv
// Core-side and peripheral-side signals of the IO bus controller.
// The master modport is the controller's view; slave is the core/peripheral side.
interface io_bus_controller_if;
  import io_bus_pkg::*;

  logic [ADDR_W-1:0]             io_address;
  logic [DATA_W-1:0]             io_write_value;
  logic                          io_read_en;
  logic                          io_write_en;
  logic [DATA_W-1:0]             io_read_value;
  logic                          stall;
  logic                          io_error;
  logic [NUM_SLOTS_C-1:0]        periph_sel;
  logic [OFFSET_W-1:0]           periph_addr;
  logic [DATA_W-1:0]             periph_wdata;
  logic                          periph_we;
  logic                          periph_req;
  logic [NUM_SLOTS_C-1:0]        periph_ack;
  logic [NUM_SLOTS_C*DATA_W-1:0] periph_rdata;

  modport master (
    input  io_address, io_write_value, io_read_en, io_write_en, periph_ack, periph_rdata,
    output io_read_value, stall, io_error, periph_sel, periph_addr, periph_wdata,
           periph_we, periph_req
  );

  modport slave (
    output io_address, io_write_value, io_read_en, io_write_en, periph_ack, periph_rdata,
    input  io_read_value, stall, io_error, periph_sel, periph_addr, periph_wdata,
           periph_we, periph_req
  );

endinterface

// File: rtl/io_slot_decode.sv
// Combinational IO address decode: one-hot slot select, slot offset and unmapped flag.
module io_slot_decode
  import io_bus_pkg::*;
(
  input  logic [UNMAPPED_BIT:0]   addr,
  output logic [NUM_SLOTS_C-1:0]  sel,
  output logic [OFFSET_W-1:0]     offset,
  output logic                    unmapped
);

  logic [SLOT_W-1:0] slot;

  always_comb begin
    slot     = addr[SLOT_LSB +: SLOT_W];
    offset   = addr[OFFSET_W-1:0];
    unmapped = addr[UNMAPPED_BIT];
    sel      = '0;
    if (!unmapped) sel[slot] = 1'b1;
  end

endmodule

// File: rtl/io_bus_controller.sv
// Bridges core IO strobes to a 4-slot peripheral request/ack bus with core stall.
// Optional ack timeout is enabled by defining IO_TIMEOUT_EN.
module io_bus_controller
  import io_bus_pkg::*;
#(
  parameter int NUM_SLOTS      = NUM_SLOTS_C,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic               clk,
  input logic               rst,
  io_bus_controller_if.master bus
);

  if (NUM_SLOTS != NUM_SLOTS_C || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("io_bus_controller: unsupported NUM_SLOTS or TIMEOUT_CYCLES");
  end

  state_t                 state_q, state_d;
  logic [NUM_SLOTS_C-1:0] sel_q;
  logic [OFFSET_W-1:0]    addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   we_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   err_q;

  logic [NUM_SLOTS_C-1:0] dec_sel;
  logic [OFFSET_W-1:0]    dec_offset;
  logic                   dec_unmapped;
  logic                   access;
  logic                   ack_hit;
  logic                   load;
  logic                   capture;
  logic                   fail;
  logic                   tmo_hit;
  logic [DATA_W-1:0]      slot_rdata;

  io_slot_decode u_decode (
    .addr     (bus.io_address[UNMAPPED_BIT:0]),
    .sel      (dec_sel),
    .offset   (dec_offset),
    .unmapped (dec_unmapped)
  );

  assign access  = bus.io_read_en | bus.io_write_en;
  // Only the latched slot's ack counts; sel_q is zero for unmapped accesses.
  assign ack_hit = |(bus.periph_ack & sel_q);

  always_comb begin
    slot_rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (sel_q[i]) slot_rdata = bus.periph_rdata[i*DATA_W +: DATA_W];
    end
  end

`ifdef IO_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count is held at zero outside REQ so every REQ entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ST_REQ) begin
      tmo_cnt_q <= '0;
    end else if (!ack_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    fail    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          load = 1'b1;
          if (dec_unmapped) begin
            state_d = ST_DONE;
            fail    = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (ack_hit) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          fail    = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= fail;
      if (load) begin
        sel_q   <= dec_sel;
        addr_q  <= dec_offset;
        wdata_q <= bus.io_write_value;
        we_q    <= bus.io_write_en;
      end
      if (fail) begin
        rdata_q <= IO_ERR_DATA;
      end else if (capture && !we_q) begin
        rdata_q <= slot_rdata;
      end
    end
  end

  assign bus.stall         = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ);
  assign bus.periph_req    = (state_q == ST_REQ);
  assign bus.periph_sel    = sel_q;
  assign bus.periph_addr   = addr_q;
  assign bus.periph_wdata  = wdata_q;
  assign bus.periph_we     = we_q;
  assign bus.io_read_value = rdata_q;
  assign bus.io_error      = err_q;

endmodule

// File: tb/tb_io_bus_controller.sv
// Randomized transaction-level bench for io_bus_controller against a reference model.
module tb_io_bus_controller;
  import io_bus_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_bus_controller_if bus ();

  io_bus_controller #(.NUM_SLOTS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One core access. k = REQ cycle on which the addressed slot acks (0 = never).
  task automatic access(input logic [15:0] addr, input logic [15:0] wv, input logic re,
                        input logic we, input int k, input logic spur, input logic [63:0] rd_bus);
    logic        mapped;
    logic [1:0]  slot;
    logic [3:0]  onehot;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          exp_stall, exp_req;
    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic        done = 1'b0;
    logic [3:0]  ack_v;

    mapped  = !addr[14];
    slot    = addr[13:12];
    onehot  = 4'b0001 << slot;
    exp_err = !mapped || (k == 0);
    exp_req = !mapped ? 0 : (k == 0 ? TMO : k);
    exp_stall = exp_req + 1;
    if (exp_err)   exp_rd = 16'hFFFF;
    else if (we)   exp_rd = last_rd;
    else           exp_rd = rd_bus[slot*16 +: 16];

    bus.periph_rdata   = rd_bus;
    bus.io_address     = addr;
    bus.io_write_value = wv;
    bus.io_read_en     = re;
    bus.io_write_en    = we;

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (bus.periph_req) begin
        req_cnt++;
        if (req_cnt == k) ack_v = onehot;
        else if (spur)    ack_v = (4'($urandom) | 4'b0100) & ~onehot;
        else              ack_v = '0;
      end else begin
        ack_v = 4'($urandom);
      end
      bus.periph_ack = ack_v;
      @(negedge clk);
      if (bus.stall) begin
        stall_cnt++;
        if (bus.periph_req) begin
          chk("sel", 32'(bus.periph_sel), 32'(onehot));
          chk("addr", 32'(bus.periph_addr), 32'(addr[11:0]));
          chk("we", 32'(bus.periph_we), 32'(we));
          chk("wdata", 32'(bus.periph_wdata), 32'(wv));
        end
      end else begin
        done = 1'b1;
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("req_cycles", req_cnt, exp_req);
        chk("rd_value", 32'(bus.io_read_value), 32'(exp_rd));
        chk("io_error", 32'(bus.io_error), 32'(exp_err));
        bus.io_read_en  = 1'b0;
        bus.io_write_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("access_bound", 0, 1);
    last_rd = exp_rd;

    bus.periph_ack = 4'($urandom);
    @(negedge clk);
    chk("idle_stall", 32'(bus.stall), 0);
    chk("idle_req", 32'(bus.periph_req), 0);
    chk("idle_err", 32'(bus.io_error), 0);
    chk("idle_rd_hold", 32'(bus.io_read_value), 32'(last_rd));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(bus.periph_req), 0);
    chk({tag, "_sel"},   32'(bus.periph_sel), 0);
    chk({tag, "_addr"},  32'(bus.periph_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.periph_wdata), 0);
    chk({tag, "_we"},    32'(bus.periph_we), 0);
    chk({tag, "_rd"},    32'(bus.io_read_value), 0);
    chk({tag, "_err"},   32'(bus.io_error), 0);
    chk({tag, "_stall"}, 32'(bus.stall), 0);
  endtask

  task automatic reset_mid_req();
    int req_seen = 0;
    bus.periph_ack     = '0;
    bus.io_address     = 16'h1008;
    bus.io_write_value = 16'h5A5A;
    bus.io_read_en     = 1'b1;
    bus.io_write_en    = 1'b0;
    for (int cyc = 0; cyc < 20 && req_seen < 3; cyc++) begin
      if (bus.periph_req) req_seen++;
      if (req_seen < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("rst_reach_req3", req_seen, 3);
    rst             = 1'b1;
    bus.io_read_en  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreq_rst");
    last_rd = 16'h0000;
    @(posedge clk); #1;
  endtask

  initial begin
    rst                = 1'b1;
    bus.io_address     = '0;
    bus.io_write_value = '0;
    bus.io_read_en     = 1'b0;
    bus.io_write_en    = 1'b0;
    bus.periph_ack     = '0;
    bus.periph_rdata   = '0;
    last_rd            = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    access(16'h1004, 16'h0000, 1'b1, 1'b0, 1, 1'b0, {16'h0, 16'h0, 16'hBEEF, 16'h0});
    access(16'h3FFF, 16'h1234, 1'b0, 1'b1, 5, 1'b0, {$urandom, $urandom});
    access(16'h4000, 16'h0000, 1'b1, 1'b0, 1, 1'b0, {$urandom, $urandom});
    access(16'h0123, 16'h0000, 1'b1, 1'b0, 3, 1'b1, {16'h1111, 16'h2222, 16'h3333, 16'h4444});
    access(16'h2002, 16'hAAAA, 1'b1, 1'b1, 2, 1'b0, {$urandom, $urandom});
    access(16'h7ABC, 16'h0F0F, 1'b0, 1'b1, 1, 1'b0, {$urandom, $urandom});

    for (int t = 0; t < 40; t++) begin
      logic [15:0] a;
      int          dir;
      a   = {1'b0, 15'($urandom)};
      dir = $urandom_range(0, 2);
      access(a, 16'($urandom), dir != 1, dir != 0, $urandom_range(1, 6), 1'($urandom),
             {$urandom, $urandom});
    end

    reset_mid_req();
    access(16'h2ABC, 16'h0000, 1'b1, 1'b0, 2, 1'b1, {$urandom, $urandom});

`ifdef IO_TIMEOUT_EN
    access(16'h2010, 16'h0000, 1'b1, 1'b0, 0, 1'b0, {$urandom, $urandom});
    access(16'h1020, 16'h0000, 1'b1, 1'b0, TMO, 1'b0, {$urandom, $urandom});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
